d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop_pkg.sv | 6 +
 rtl/d_flip_flop_latch.sv | 29 ++
 rtl/d_flip_flop.sv | 39 +++
 tb/tb_d_flip_flop.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/d_flip_flop_pkg.sv
// Shared defaults for the flip-flop storage cells.
package d_flip_flop_pkg;

    localparam int DFF_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/d_flip_flop_latch.sv
// Level-sensitive latch: transparent while en=1, holds while en=0,
// and rst forces the stored value asynchronously.
module d_latch
    import d_flip_flop_pkg::*;
#(
    parameter int WIDTH = DFF_DEFAULT_WIDTH
) (
    input  logic             en,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] q_r;

    always_latch begin
        if (rst) begin
            q_r <= rst_val;
        end else if (en) begin
            q_r <= d;
        end
    end

    assign q     = q_r;
    assign q_bar = ~q_r;

endmodule

// File: rtl/d_flip_flop.sv
// Rising-edge D flip-flop built from a master/slave latch pair, with
// complementary outputs and asynchronous active-high reset.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    input  logic             rst
);

    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] unused_master_q_bar;

    // Master follows data while clk is low, so it holds the pre-edge value
    // once clk rises; the slave then exposes it for the whole high phase.
    d_latch #(.WIDTH(WIDTH)) u_master (
        .en      (~clk),
        .rst     (rst),
        .rst_val (RESET_VALUE),
        .d       (data),
        .q       (master_q),
        .q_bar   (unused_master_q_bar)
    );

    d_latch #(.WIDTH(WIDTH)) u_slave (
        .en      (clk),
        .rst     (rst),
        .rst_val (RESET_VALUE),
        .d       (master_q),
        .q       (q),
        .q_bar   (q_bar)
    );

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: stimulus queues expected outputs,
// a monitor pops and compares them when a sample point is signalled.
`timescale 1ns/1ps
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic       data;
    logic       q1;
    logic       qb1;
    logic       rst4;
    logic [3:0] data4;
    logic [3:0] q4;
    logic [3:0] qb4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        bit         wide;
        logic [3:0] q;
        logic [3:0] qb;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    d_flip_flop dut_1 (
        .clk   (clk),
        .data  (data),
        .q     (q1),
        .q_bar (qb1),
        .rst   (rst)
    );

    d_flip_flop #(.WIDTH(4), .RESET_VALUE(4'hA)) dut_4 (
        .clk   (clk),
        .data  (data4),
        .q     (q4),
        .q_bar (qb4),
        .rst   (rst4)
    );

    // Let the design settle, queue the expectation, hand it to the monitor.
    task automatic chk(input string name, input bit wide, input logic [3:0] eq);
        exp_t e;
        #1;
        e.name = name;
        e.wide = wide;
        e.q    = wide ? eq : {3'b000, eq[0]};
        e.qb   = wide ? ~eq : {3'b000, ~eq[0]};
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] aq;
        logic [3:0] aqb;
        forever begin
            @(sample_ev);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sample_without_expectation at %0t", $time);
            end else begin
                e = sb.pop_front();
                aq  = e.wide ? q4  : {3'b000, q1};
                aqb = e.wide ? qb4 : {3'b000, qb1};
                if (aq !== e.q || aqb !== e.qb) begin
                    errors++;
                    $display("FAIL %s at %0t: q=%h q_bar=%h, required q=%h q_bar=%h",
                             e.name, $time, aq, aqb, e.q, e.qb);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        clk   = 0;
        rst   = 1;
        data  = 1;
        rst4  = 1;
        data4 = 4'h3;

        // 1: reset dominates clock edges on both instances
        for (int i = 0; i < 3; i++) begin
            #3 clk = 1;
            chk("rst_hold_hi", 0, 4'h0);
            chk("rst4_hold_hi", 1, 4'hA);
            #3 clk = 0;
            chk("rst_hold_lo", 0, 4'h0);
        end
        rst = 0;
        #5;
        chk("after_release_no_edge", 0, 4'h0);
        clk = 1;
        chk("first_capture", 0, 4'h1);

        // 2: capture 0, then hold through low phase with data=1
        #5 clk = 0; data = 0;
        chk("hold_at_fall", 0, 4'h1);
        #5 clk = 1;
        chk("capture_0", 0, 4'h0);
        #5 clk = 0; data = 1;
        #10;
        chk("hold_low_10ns", 0, 4'h0);

        // 3: capture 1, hold with data=0 until next edge
        clk = 1;
        chk("capture_1", 0, 4'h1);
        #5 clk = 0; data = 0;
        chk("hold_1_fall", 0, 4'h1);
        #10;
        chk("hold_1_low", 0, 4'h1);
        clk = 1;
        chk("next_edge_0", 0, 4'h0);

        // 4: data wiggles while clk is high and low never reach q
        for (int i = 0; i < 4; i++) begin
            #1 data = ~data;
            chk("wiggle_hi_0", 0, 4'h0);
        end
        clk = 0;
        for (int i = 0; i < 4; i++) begin
            #1 data = ~data;
            chk("wiggle_lo_0", 0, 4'h0);
        end
        data = 1;
        #2 clk = 1;
        chk("wiggle_edge_1", 0, 4'h1);
        for (int i = 0; i < 3; i++) begin
            #1 data = ~data;
            chk("wiggle_hi_1", 0, 4'h1);
        end

        // 5: async reset mid high phase, release coincident with an edge
        data = 1;
        rst = 1;
        chk("async_rst_drop", 0, 4'h0);
        #3 clk = 0;
        #5;
        rst = 0;
        clk = 1;
        chk("release_on_edge", 0, 4'h0);
        #5 clk = 0;
        chk("release_hold_low", 0, 4'h0);
        #5 clk = 1;
        chk("post_release_capture", 0, 4'h1);

        // 6: wide instance with non-zero reset value
        #5 clk = 0;
        chk("rst4_value", 1, 4'hA);
        rst4 = 0;
        #5 clk = 1;
        chk("wide_capture_3", 1, 4'h3);
        #5 clk = 0; data4 = 4'h6;
        chk("wide_hold_fall", 1, 4'h3);
        #5 clk = 1;
        chk("wide_capture_6", 1, 4'h6);
        rst4 = 1;
        chk("wide_async_rst", 1, 4'hA);

        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
